result_stream_collector: RTL and testbench

Receive-side partner of the matrix engine's streamed C output. Accepts N beats of N results over a valid/ready stream, one row or one column per beat. Drives the engine's output_by_row direction select. Reassembles the full NxN matrix in row-major order and presents it on a matrix-wide valid/ready interface to the downstream consumer (writeback, accumulator or next layer).

---
 rtl/result_stream_collector.sv | 189 ++++++++++++++++++
 tb/tb_result_stream_collector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_collector.sv
// Purpose : collect N beats of N results from the matrix engine and present the full NxN matrix in row-major order.
// Latency : m_valid rises the cycle after the Nth beat; m_data is registered with no combinational path from s_data.
// Backpr. : s_ready=0 while no bank is free; the matrix is held stable on m_data until m_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   collect_by_row : requested direction (1 = rows, 0 = columns), taken on the first beat only
//   clear          : synchronous discard of any partial or buffered matrix
//   s_valid/s_ready/s_by_row/s_data : engine result stream, N lanes per beat
//   m_valid/m_ready/m_data          : matrix-wide output, m_data[i][j] = row i, column j
//   beat_idx       : beats accepted into the matrix currently being collected
//
// Build option COLLECTOR_DBUF_EN: two ping-pong banks so collection of the next matrix
// overlaps draining of the previous one (N cycles per matrix instead of N+1).
module result_stream_collector #(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = 2*DATA_WIDTH+$clog2(N)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      collect_by_row,
    input  logic                                      clear,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    output logic                                      s_by_row,
    input  logic [N-1:0][C_DATA_WIDTH-1:0]            s_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0]     m_data,
    output logic [$clog2(N+1)-1:0]                    beat_idx
);
    localparam int BW = $clog2(N+1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N-1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    typedef logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0] mat_t;

    logic          first_beat;
    logic          eff_row;
    logic          beat;
    logic          last_beat;
    logic [IW-1:0] wr_idx;

    assign first_beat = (beat_idx == '0);
    assign last_beat  = (beat_idx == LAST_BEAT);
    assign wr_idx     = beat_idx[IW-1:0];
    assign s_by_row   = eff_row;
    // A beat coincident with clear is dropped.
    assign beat       = s_valid && s_ready && !clear;

`ifdef COLLECTOR_DBUF_EN
    state_t        bank_q [2];
    state_t        bank_d [2];
    logic [1:0]    mode_reg;
    logic          fill_sel;
    logic          drain_sel;
    mat_t [1:0]    mat_buf;
    logic          drain_hs;

    // Direction is latched per bank so each matrix keeps the mode of its own first beat.
    assign eff_row  = first_beat ? collect_by_row : mode_reg[fill_sel];
    assign m_data   = mat_buf[drain_sel];
    assign drain_hs = m_valid && m_ready && !clear;

    always_comb begin
        bank_d  = bank_q;
        // Fill bank only ever points at a FULL bank when both banks are FULL.
        s_ready = (bank_q[fill_sel] == COLLECT);
        m_valid = (bank_q[drain_sel] == FULL);
        if (s_ready && s_valid && last_beat) begin
            bank_d[fill_sel] = FULL;
        end
        // Fill and drain never target the same bank in one cycle: a draining bank is FULL.
        if (m_valid && m_ready) begin
            bank_d[drain_sel] = COLLECT;
        end
        if (clear) begin
            bank_d[0] = COLLECT;
            bank_d[1] = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q[0] <= COLLECT;
            bank_q[1] <= COLLECT;
            mode_reg  <= '0;
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            beat_idx  <= '0;
            mat_buf   <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            if (clear) begin
                beat_idx  <= '0;
                fill_sel  <= 1'b0;
                drain_sel <= 1'b0;
            end else begin
                if (drain_hs) begin
                    drain_sel <= ~drain_sel;
                end
                if (beat) begin
                    beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
                    if (last_beat) begin
                        fill_sel <= ~fill_sel;
                    end
                    if (first_beat) begin
                        mode_reg[fill_sel] <= collect_by_row;
                    end
                    for (int j = 0; j < N; j++) begin
                        if (eff_row) begin
                            mat_buf[fill_sel][wr_idx][j] <= s_data[j];
                        end else begin
                            mat_buf[fill_sel][j][wr_idx] <= s_data[j];
                        end
                    end
                end
            end
        end
    end
`else
    state_t state_q;
    state_t state_d;
    logic   mode_reg;
    mat_t   mat_buf;

    assign eff_row = first_beat ? collect_by_row : mode_reg;
    assign m_data  = mat_buf;

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                s_ready = 1'b1;
                if (s_valid && last_beat) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        if (clear) begin
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= COLLECT;
            mode_reg <= 1'b0;
            beat_idx <= '0;
            mat_buf  <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                // Buffer contents are left as they are; only the bookkeeping is reset.
                beat_idx <= '0;
            end else if (beat) begin
                beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
                if (first_beat) begin
                    mode_reg <= collect_by_row;
                end
                for (int j = 0; j < N; j++) begin
                    if (eff_row) begin
                        mat_buf[wr_idx][j] <= s_data[j];
                    end else begin
                        mat_buf[j][wr_idx] <= s_data[j];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_result_stream_collector.sv
// Purpose : self-checking bench for result_stream_collector (directed cases plus random traffic).
// Latency : inputs driven 1 ns after each rising edge, outputs compared 1 ns later.
// Backpr. : random s_valid/m_ready/clear exercise both stall directions.
module tb_result_stream_collector;
    localparam int DATA_WIDTH = 8;
    localparam int N          = 4;
    localparam int CW         = 2*DATA_WIDTH + $clog2(N);
    localparam int BW         = $clog2(N+1);
    localparam int MW         = N*N*CW;
`ifdef COLLECTOR_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef logic [N-1:0][CW-1:0]        beat_t;
    typedef logic [N-1:0][N-1:0][CW-1:0] mat_t;

    logic          clk            = 1'b0;
    logic          reset          = 1'b0;
    logic          collect_by_row = 1'b0;
    logic          clear          = 1'b0;
    logic          s_valid        = 1'b0;
    logic          m_ready        = 1'b0;
    beat_t         s_data         = '0;
    logic          s_ready;
    logic          s_by_row;
    logic          m_valid;
    mat_t          m_data;
    logic [BW-1:0] beat_idx;

    int errors = 0;
    int checks = 0;

    // Reference model: completed matrices waiting for the consumer, plus the partial one.
    mat_t  mq[$];
    beat_t pb [N];
    int    pcnt  = 0;
    logic  pmode = 1'b0;

    result_stream_collector #(
        .DATA_WIDTH(DATA_WIDTH),
        .N(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .collect_by_row(collect_by_row),
        .clear(clear),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_by_row(s_by_row),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .beat_idx(beat_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int k, input int base);
        beat_t d;
        for (int j = 0; j < N; j++) d[j] = CW'(base + N*k + j + 1);
        return d;
    endfunction

    function automatic mat_t exp_mat(input bit row, input int base);
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = row ? CW'(base + N*i + j + 1) : CW'(base + N*j + i + 1);
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        pcnt  = 0;
        pmode = 1'b0;
    endtask

    // Applies the effect of one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit   rdy;
        bit   vld;
        mat_t m;
        rdy = (mq.size() < NB);
        vld = (mq.size() > 0);
        if (clear) begin
            mq.delete();
            pcnt = 0;
        end else begin
            if (vld && m_ready) void'(mq.pop_front());
            if (s_valid && rdy) begin
                if (pcnt == 0) pmode = collect_by_row;
                pb[pcnt] = s_data;
                pcnt++;
                if (pcnt == N) begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            m[i][j] = pmode ? pb[i][j] : pb[j][i];
                    mq.push_back(m);
                    pcnt = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_by_row;
        exp_by_row = (pcnt == 0) ? collect_by_row : pmode;
        check({tag, ".s_ready"},  MW'(s_ready),  MW'(mq.size() < NB));
        check({tag, ".m_valid"},  MW'(m_valid),  MW'(mq.size() > 0));
        check({tag, ".beat_idx"}, MW'(beat_idx), MW'(pcnt));
        check({tag, ".s_by_row"}, MW'(s_by_row), MW'(exp_by_row));
        if (mq.size() > 0) check({tag, ".m_data"}, m_data, mq[0]);
    endtask

    // One clock: drive inputs, compare against the model, take the edge. want_row < 0 skips
    // the fixed direction check.
    task automatic drive(input string tag, input logic v, input logic row, input logic mr,
                         input logic clr, input beat_t d, input int want_row);
        s_valid = v; collect_by_row = row; m_ready = mr; clear = clr; s_data = d;
        #1;
        check_outputs(tag);
        if (want_row >= 0) check({tag, ".dir"}, MW'(s_by_row), MW'(want_row));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2*NB && mq.size() > 0; i++) drive("drain", 0, 1, 1, 0, '0, -1);
        check("drain.empty", MW'(mq.size()), MW'(0));
    endtask

    initial begin
        // Reset state
        #3;
        check("rst.m_valid",  MW'(m_valid),  MW'(0));
        check("rst.beat_idx", MW'(beat_idx), MW'(0));
        check("rst.m_data",   m_data,        '0);
        #9 reset = 1'b1;
        @(posedge clk); #1;
        check("rst.s_ready", MW'(s_ready), MW'(1));

        // Row mode
        for (int k = 0; k < N; k++) drive("row", 1, 1, 0, 0, mk(k, 0), 1);
        check("row.m_valid", MW'(m_valid), MW'(1));
        check("row.s_ready", MW'(s_ready), MW'(NB == 2));
        check("row.m_data",  m_data, exp_mat(1, 0));
        drive("row.pop", 0, 1, 1, 0, '0, -1);
        check("row.pop.m_valid", MW'(m_valid), MW'(0));
        check("row.pop.s_ready", MW'(s_ready), MW'(1));

        // Column mode gives the transpose
        for (int k = 0; k < N; k++) drive("col", 1, 0, 0, 0, mk(k, 0), 0);
        check("col.m_data", m_data, exp_mat(0, 0));
        drain();

        // Direction changes after the first beat are ignored
        for (int k = 0; k < N; k++) drive("tog", 1, (k == 0), 0, 0, mk(k, 0), 1);
        check("tog.m_data", m_data, exp_mat(1, 0));

        // Consumer stalls for 10 cycles with the engine pushing
        for (int k = 0; k < 10; k++) drive("hold", 1, 1, 0, 0, mk(k % N, 50), -1);
        check("hold.beat_idx", MW'(beat_idx), MW'(0));
        check("hold.s_ready",  MW'(s_ready),  MW'(0));
        check("hold.m_data",   m_data, exp_mat(1, 0));
        drive("hold.pop", 0, 1, 1, 0, '0, -1);
        check("hold.pop.m_valid", MW'(m_valid), MW'(NB == 2));
        check("hold.pop.s_ready", MW'(s_ready), MW'(1));
        drain();
        for (int k = 0; k < N; k++) drive("next", 1, 1, 0, 0, mk(k, 100), 1);
        check("next.m_data", m_data, exp_mat(1, 100));
        drain();

        // Asynchronous reset mid-collection
        for (int k = 0; k < 2; k++) drive("arst", 1, 1, 0, 0, mk(k, 150), 1);
        #2;
        s_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check("arst.m_valid",  MW'(m_valid),  MW'(0));
        check("arst.beat_idx", MW'(beat_idx), MW'(0));
        check("arst.m_data",   m_data, '0);
        model_reset();
        #3 reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < N; k++) drive("arst.fresh", 1, 0, 0, 0, mk(k, 200), 0);
        check("arst.fresh.m_data", m_data, exp_mat(0, 200));
        drain();

        // clear mid-collection, with a coincident beat
        for (int k = 0; k < 2; k++) drive("clr", 1, 1, 0, 0, mk(k, 300), 1);
        drive("clr.hit", 1, 1, 0, 1, mk(2, 300), 1);
        check("clr.beat_idx", MW'(beat_idx), MW'(0));
        check("clr.m_valid",  MW'(m_valid),  MW'(0));
        for (int k = 0; k < N; k++) drive("clr.fresh", 1, 1, 0, 0, mk(k, 400), 1);
        check("clr.fresh.m_data", m_data, exp_mat(1, 400));
        // clear also discards a buffered matrix
        drive("clr.full", 0, 1, 0, 1, '0, -1);
        check("clr.full.m_valid", MW'(m_valid), MW'(0));

`ifdef COLLECTOR_DBUF_EN
        // Two matrices back-to-back with the consumer stalled
        for (int k = 0; k < 2*N; k++) begin
            drive("dbuf", 1, 1, 0, 0, mk(k % N, (k < N) ? 500 : 600), 1);
        end
        check("dbuf.s_ready", MW'(s_ready), MW'(0));
        check("dbuf.m_data1", m_data, exp_mat(1, 500));
        drive("dbuf.pop", 0, 1, 1, 0, '0, -1);
        check("dbuf.m_data2",  m_data, exp_mat(1, 600));
        check("dbuf.s_ready2", MW'(s_ready), MW'(1));
        drain();
`endif

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            beat_t d;
            for (int j = 0; j < N; j++) d[j] = CW'($urandom);
            drive("rnd", ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 40) == 0), d, -1);
        end
        #1;
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
